// File: rtl/alu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_pkg
//   Shared definitions for the ALU control sequencer:
//     - op codes (ADC..ROR) as an enum
//     - sequencer states as an enum
//     - per-op flag update masks, ordered {N,V,Z,C}
//     - small decode helpers used by the sequencer
// -----------------------------------------------------------------------------
package alu_seq_ctrl_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADC = 3'd0,
    OP_SBC = 3'd1,
    OP_CMP = 3'd2,
    OP_AND = 3'd3,
    OP_EOR = 3'd4,
    OP_ORA = 3'd5,
    OP_LSR = 3'd6,
    OP_ROR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Flag vectors are always ordered {N,V,Z,C}.
  localparam logic [3:0] MASK_NVZC = 4'b1111;
  localparam logic [3:0] MASK_NZC  = 4'b1011;
  localparam logic [3:0] MASK_NZ   = 4'b1010;

  // Which status bits an op is allowed to overwrite at the capture edge.
  function automatic logic [3:0] flag_mask(input op_t op);
    logic [3:0] m;
    m = MASK_NZ;
    case (op)
      OP_ADC, OP_SBC:          m = MASK_NVZC;
      OP_CMP:                  m = MASK_NZC;
      OP_AND, OP_EOR, OP_ORA:  m = MASK_NZ;
      OP_LSR, OP_ROR:          m = MASK_NZC;
      default:                 m = MASK_NZ;
    endcase
    return m;
  endfunction

  // Ops whose carry-in comes from the architectural C flag.
  function automatic logic uses_p_c(input op_t op);
    return (op == OP_ADC) || (op == OP_SBC) || (op == OP_ROR);
  endfunction

  // Decimal mode only affects the adder/subtractor.
  function automatic logic is_arith(input op_t op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_if
//   Bundle between the decoder/ALU environment and the sequencer.
//   Request handshake (valid/ready):
//     An op transfers on a rising clk edge where req_valid and req_ready are
//     both high. req_ready is high only in IDLE (and low during reset).
//     The requester holds req_valid, req_op and req_dst stable until it sees
//     req_ready; req_valid while not ready is ignored.
//   Modports:
//     slave  - the sequencer (alu_seq_ctrl)
//     master - decoder + ALU side (drives request, status, flag load)
// -----------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
  parameter int OPW = 3
);
  // request handshake
  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic           req_dst;

  // P-register side inputs
  logic           d_flag;
  logic           flag_ld;
  logic [3:0]     flag_ld_val;

  // ALU combinational status
  logic           alu_cout;
  logic           alu_zero;
  logic           alu_ovf;
  logic           alu_neg;

  // ALU control
  logic           alu_sums;
  logic           alu_subs;
  logic           alu_ands;
  logic           alu_eors;
  logic           alu_ors;
  logic           alu_shftr;
  logic           alu_shftcr;
  logic           alu_cin;
  logic           alu_decen;
  logic           alu_reset;
  logic           alu_adloa;
  logic           alu_sboa;

  // completion and status flags
  logic           done;
  logic           p_n;
  logic           p_v;
  logic           p_z;
  logic           p_c;

  modport slave (
    input  req_valid, req_op, req_dst,
    input  d_flag, flag_ld, flag_ld_val,
    input  alu_cout, alu_zero, alu_ovf, alu_neg,
    output req_ready,
    output alu_sums, alu_subs, alu_ands, alu_eors, alu_ors, alu_shftr, alu_shftcr,
    output alu_cin, alu_decen, alu_reset, alu_adloa, alu_sboa,
    output done, p_n, p_v, p_z, p_c
  );

  modport master (
    output req_valid, req_op, req_dst,
    output d_flag, flag_ld, flag_ld_val,
    output alu_cout, alu_zero, alu_ovf, alu_neg,
    input  req_ready,
    input  alu_sums, alu_subs, alu_ands, alu_eors, alu_ors, alu_shftr, alu_shftcr,
    input  alu_cin, alu_decen, alu_reset, alu_adloa, alu_sboa,
    input  done, p_n, p_v, p_z, p_c
  );

endinterface

// File: rtl/alu_seq_ctrl_flag_reg.sv
// -----------------------------------------------------------------------------
// alu_flag_reg
//   4-bit {N,V,Z,C} status register.
//   Ports:
//     clk, reset    - clock, synchronous active-high reset (loads RST_VAL)
//     i_cap_en      - capture ALU status this edge
//     i_cap_mask    - bits the capture is allowed to overwrite
//     i_cap_val     - ALU status {N,V,Z,C}
//     i_ld          - direct load of all four bits
//     i_ld_val      - value for the direct load
//     o_flags       - registered {N,V,Z,C}
//   Merge order: direct load forms the base value, then the capture
//   overwrites the masked bits, so the ALU wins where both touch a bit.
// -----------------------------------------------------------------------------
module alu_flag_reg #(
  parameter logic [3:0] RST_VAL = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cap_en,
  input  logic [3:0] i_cap_mask,
  input  logic [3:0] i_cap_val,
  input  logic       i_ld,
  input  logic [3:0] i_ld_val,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic [3:0] w_base;
  logic [3:0] w_next;

  always_comb begin
    w_base = i_ld ? i_ld_val : r_flags;
    w_next = w_base;
    if (i_cap_en) begin
      w_next = (i_cap_val & i_cap_mask) | (w_base & ~i_cap_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= RST_VAL;
    end else begin
      r_flags <= w_next;
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//   Sequencer owning the 8-bit ALU control strobes. Accepts one op at a time,
//   drives one execute cycle (one-hot function strobe, carry-in, decimal
//   enable), then one output cycle (result onto ADL or SB, done pulse), and
//   keeps the N/V/Z/C flags with 6502 per-op update masks.
//   Ports:
//     clk          - system clock
//     reset        - synchronous active-high reset, highest priority
//     bus          - alu_seq_ctrl_if.slave (request, ALU control/status, flags)
//     o_dbg_state  - current FSM state, for observation only
//   Timing: accept at edge T, EXEC in cycle T+1, OUT (result + done) in T+2,
//   next accept at edge T+3.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int         OPW      = 3,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  alu_seq_ctrl_if.slave       bus,
  output state_t              o_dbg_state
);

  state_t         r_state;
  state_t         w_next_state;
  logic [OPW-1:0] r_op;
  logic           r_dst;
  op_t            w_op;

  // Unqualified (pre-reset-gating) control outputs
  logic       w_ready;
  logic [6:0] w_strb;      // {shftcr, shftr, ors, eors, ands, subs, sums}
  logic       w_cin;
  logic       w_decen;
  logic       w_adloa;
  logic       w_sboa;
  logic       w_done;
  logic       w_cap_en;

  logic [3:0] w_flags;

  assign w_op = op_t'(r_op);

  // ---------------------------------------------------------------------------
  // State and request latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_dst   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && bus.req_valid) begin
        r_op  <= bus.req_op;
        r_dst <= bus.req_dst;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and per-state controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_strb       = '0;
    w_cin        = 1'b0;
    w_decen      = 1'b0;
    w_adloa      = 1'b0;
    w_sboa       = 1'b0;
    w_done       = 1'b0;
    w_cap_en     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          w_next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        case (w_op)
          OP_ADC:         w_strb = 7'b000_0001;
          OP_SBC, OP_CMP: w_strb = 7'b000_0010;
          OP_AND:         w_strb = 7'b000_0100;
          OP_EOR:         w_strb = 7'b000_1000;
          OP_ORA:         w_strb = 7'b001_0000;
          OP_LSR:         w_strb = 7'b010_0000;
          OP_ROR:         w_strb = 7'b100_0000;
          default:        w_strb = 7'b000_0000;
        endcase
        // CMP is a subtract with no borrow in; the others needing a carry
        // take it from the architectural C flag.
        if (w_op == OP_CMP) begin
          w_cin = 1'b1;
        end else if (uses_p_c(w_op)) begin
          w_cin = w_flags[0];
        end
        w_decen      = bus.d_flag & is_arith(w_op);
        w_cap_en     = 1'b1;
        w_next_state = S_OUT;
      end

      S_OUT: begin
        w_done       = 1'b1;
        // CMP only produces flags; its result never reaches a bus.
        w_adloa      = ~r_dst & (w_op != OP_CMP);
        w_sboa       =  r_dst & (w_op != OP_CMP);
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  alu_flag_reg #(
    .RST_VAL (FLAG_RST)
  ) u_flag_reg (
    .clk        (clk),
    .reset      (reset),
    .i_cap_en   (w_cap_en),
    .i_cap_mask (flag_mask(w_op)),
    .i_cap_val  ({bus.alu_neg, bus.alu_ovf, bus.alu_zero, bus.alu_cout}),
    .i_ld       (bus.flag_ld),
    .i_ld_val   (bus.flag_ld_val),
    .o_flags    (w_flags)
  );

  // ---------------------------------------------------------------------------
  // Outputs. Reset forces every control low in the same cycle, so a reset
  // arriving mid-EXEC or mid-OUT never leaves a strobe or enable asserted.
  // ---------------------------------------------------------------------------
  assign bus.req_ready  = w_ready    & ~reset;
  assign bus.alu_sums   = w_strb[0]  & ~reset;
  assign bus.alu_subs   = w_strb[1]  & ~reset;
  assign bus.alu_ands   = w_strb[2]  & ~reset;
  assign bus.alu_eors   = w_strb[3]  & ~reset;
  assign bus.alu_ors    = w_strb[4]  & ~reset;
  assign bus.alu_shftr  = w_strb[5]  & ~reset;
  assign bus.alu_shftcr = w_strb[6]  & ~reset;
  assign bus.alu_cin    = w_cin      & ~reset;
  assign bus.alu_decen  = w_decen    & ~reset;
  assign bus.alu_adloa  = w_adloa    & ~reset;
  assign bus.alu_sboa   = w_sboa     & ~reset;
  assign bus.done       = w_done     & ~reset;
  assign bus.alu_reset  = reset;

  assign bus.p_n = w_flags[3];
  assign bus.p_v = w_flags[2];
  assign bus.p_z = w_flags[1];
  assign bus.p_c = w_flags[0];

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Bench for alu_seq_ctrl. A small binary ALU model answers the strobes with
//   status and a result register; a separate op-level reference computes the
//   expected result and flags with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.OPW(3)) bus ();
  state_t dbg_state;

  alu_seq_ctrl #(
    .OPW      (3),
    .FLAG_RST (4'b0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] m_flags;   // model of {N,V,Z,C}

  // ---------------------------------------------------------------------------
  // ALU model: combinational status from strobes, result register on clk
  // ---------------------------------------------------------------------------
  logic [7:0] a_in, b_in, alu_res;
  logic [8:0] alu_r;
  logic       alu_v, alu_c;

  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    if (bus.alu_sums) begin
      alu_r = {1'b0, a_in} + {1'b0, b_in} + {8'b0, bus.alu_cin};
      alu_c = alu_r[8];
      alu_v = (a_in[7] == b_in[7]) && (alu_r[7] != a_in[7]);
    end else if (bus.alu_subs) begin
      alu_r = {1'b0, a_in} + {1'b0, ~b_in} + {8'b0, bus.alu_cin};
      alu_c = alu_r[8];
      alu_v = (a_in[7] != b_in[7]) && (alu_r[7] != a_in[7]);
    end else if (bus.alu_ands) begin
      alu_r = {1'b0, a_in & b_in};
    end else if (bus.alu_eors) begin
      alu_r = {1'b0, a_in ^ b_in};
    end else if (bus.alu_ors) begin
      alu_r = {1'b0, a_in | b_in};
    end else if (bus.alu_shftr) begin
      alu_r = {2'b0, a_in[7:1]};
      alu_c = a_in[0];
    end else if (bus.alu_shftcr) begin
      alu_r = {1'b0, bus.alu_cin, a_in[7:1]};
      alu_c = a_in[0];
    end
    bus.alu_cout = alu_c;
    bus.alu_ovf  = alu_v;
    bus.alu_neg  = alu_r[7];
    bus.alu_zero = (alu_r[7:0] == 8'h00);
  end

  always @(posedge clk) begin
    if (bus.alu_sums | bus.alu_subs | bus.alu_ands | bus.alu_eors |
        bus.alu_ors | bus.alu_shftr | bus.alu_shftcr)
      alu_res <= alu_r[7:0];
  end

  function automatic logic [6:0] strobes();
    return {bus.alu_shftcr, bus.alu_shftr, bus.alu_ors, bus.alu_eors,
            bus.alu_ands, bus.alu_subs, bus.alu_sums};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.p_n, bus.p_v, bus.p_z, bus.p_c};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference: 6502 semantics per op. Returns {result, N, V, Z, C}.
  // base supplies the bits an op leaves alone.
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin,
                                         input logic [3:0] base);
    int s, ss;
    logic [7:0] res;
    logic n, v, z, c;
    {n, v, z, c} = base;
    res = 8'h00;
    case (op)
      3'd0: begin  // ADC
        s   = int'(a) + int'(b) + int'(cin);
        ss  = int'($signed(a)) + int'($signed(b)) + int'(cin);
        res = s[7:0];
        c   = (s > 255);
        v   = (ss > 127) || (ss < -128);
      end
      3'd1: begin  // SBC
        s   = int'(a) - int'(b) - (cin ? 0 : 1);
        ss  = int'($signed(a)) - int'($signed(b)) - (cin ? 0 : 1);
        res = s[7:0];
        c   = (s >= 0);
        v   = (ss > 127) || (ss < -128);
      end
      3'd2: begin  // CMP
        s   = int'(a) - int'(b);
        res = s[7:0];
        c   = (a >= b);
      end
      3'd3: res = a & b;
      3'd4: res = a ^ b;
      3'd5: res = a | b;
      3'd6: begin res = a >> 1; c = a[0]; end
      default: begin res = (a >> 1) | (cin ? 8'h80 : 8'h00); c = a[0]; end
    endcase
    n = res[7];
    z = (res == 8'h00);
    return {res, n, v, z, c};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called right after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic set_flags(input logic [3:0] v);
    bus.flag_ld     = 1'b1;
    bus.flag_ld_val = v;
    @(posedge clk); #1;
    bus.flag_ld     = 1'b0;
    m_flags         = v;
    @(negedge clk);
    n_checks++;
    if (flags() !== v) $display("FAIL set_flags: got %b want %b", flags(), v);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic dst, input logic [7:0] a,
                        input logic [7:0] b, input logic d, input logic ld,
                        input logic [3:0] ldv, input string tag);
    logic [11:0] r;
    logic [6:0]  exp_strb;
    logic        exp_cin;
    int          waitc;
    a_in = a; b_in = b; bus.d_flag = d;
    bus.req_op = op; bus.req_dst = dst; bus.req_valid = 1'b1;
    waitc = 0;
    @(negedge clk);
    while (!bus.req_ready && waitc < 10) begin @(negedge clk); waitc++; end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL %s accept: req_ready got %b want 1 within 10 cycles", tag, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (ld) begin bus.flag_ld = 1'b1; bus.flag_ld_val = ldv; end

    // EXEC cycle
    case (op)
      3'd0: exp_strb = 7'b000_0001;
      3'd1, 3'd2: exp_strb = 7'b000_0010;
      3'd3: exp_strb = 7'b000_0100;
      3'd4: exp_strb = 7'b000_1000;
      3'd5: exp_strb = 7'b001_0000;
      3'd6: exp_strb = 7'b010_0000;
      default: exp_strb = 7'b100_0000;
    endcase
    exp_cin = (op == 3'd2) ? 1'b1 :
              (op == 3'd0 || op == 3'd1 || op == 3'd7) ? m_flags[0] : 1'b0;
    r = ref_op(op, a, b, m_flags[0], ld ? ldv : m_flags);
    @(negedge clk);
    n_checks++;
    if (strobes() !== exp_strb) $display("FAIL %s exec_strobes: got %b want %b", tag, strobes(), exp_strb);
    else n_pass++;
    n_checks++;
    if (bus.alu_cin !== exp_cin) $display("FAIL %s exec_cin: got %b want %b", tag, bus.alu_cin, exp_cin);
    else n_pass++;
    n_checks++;
    if (bus.alu_decen !== (d & (op <= 3'd1))) $display("FAIL %s exec_decen: got %b want %b", tag, bus.alu_decen, d & (op <= 3'd1));
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.req_ready, bus.alu_adloa, bus.alu_sboa} !== 4'b0000)
      $display("FAIL %s exec_quiet: got done/ready/adloa/sboa %b want 0000", tag,
               {bus.done, bus.req_ready, bus.alu_adloa, bus.alu_sboa});
    else n_pass++;
    @(posedge clk); #1;
    bus.flag_ld = 1'b0;

    // OUT cycle
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1) $display("FAIL %s out_done: got %b want 1", tag, bus.done);
    else n_pass++;
    n_checks++;
    if ({bus.alu_adloa, bus.alu_sboa} !== ((op == 3'd2) ? 2'b00 : (dst ? 2'b01 : 2'b10)))
      $display("FAIL %s out_oe: got adloa/sboa %b want %b", tag, {bus.alu_adloa, bus.alu_sboa},
               (op == 3'd2) ? 2'b00 : (dst ? 2'b01 : 2'b10));
    else n_pass++;
    n_checks++;
    if ({strobes(), bus.alu_decen} !== 8'h00) $display("FAIL %s out_strobes: got %b want 0", tag, {strobes(), bus.alu_decen});
    else n_pass++;
    n_checks++;
    if (alu_res !== r[11:4]) $display("FAIL %s result: got %h want %h", tag, alu_res, r[11:4]);
    else n_pass++;
    n_checks++;
    if (flags() !== r[3:0]) $display("FAIL %s flags: got %b want %b", tag, flags(), r[3:0]);
    else n_pass++;
    m_flags = r[3:0];
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.alu_reset} !== 2'b01)
      $display("FAIL reset_hold: got ready/alu_reset %b want 01", {bus.req_ready, bus.alu_reset});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
    else n_pass++;
    n_checks++;
    if (flags() !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", flags());
    else n_pass++;
    n_checks++;
    if ({bus.req_ready, bus.done, bus.alu_reset, strobes()} !== 10'b1_0_0_0000000)
      $display("FAIL reset_outputs: got %b want 1000000000", {bus.req_ready, bus.done, bus.alu_reset, strobes()});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    set_flags(4'b0000);
    run_op(3'd0, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0, 4'h0, "adc_50_50");
    set_flags(4'b0001);
    run_op(3'd1, 1'b1, 8'h05, 8'h03, 1'b0, 1'b0, 4'h0, "sbc_05_03");
    set_flags(4'b0100);
    run_op(3'd2, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0, 4'h0, "cmp_equal");
    set_flags(4'b0001);
    run_op(3'd3, 1'b0, 8'hF0, 8'h0F, 1'b0, 1'b0, 4'h0, "and_zero");
    run_op(3'd7, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 4'h0, "ror_carry");
  endtask

  task automatic test_decimal_and_merge();
    set_flags(4'b0000);
    run_op(3'd0, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 4'h0, "adc_decen");
    run_op(3'd4, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 4'h0, "eor_no_decen");
    // flag_ld coinciding with capture: V and C come from the load
    run_op(3'd5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 4'b1111, "ora_ld_merge");
    run_op(3'd6, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, 4'b0000, "lsr_ld_merge");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    int   acc, dones;
    logic prev_done, rdy;
    acc = 0; dones = 0; prev_done = 1'b0;
    a_in = 8'h3C; b_in = 8'h5A; bus.d_flag = 1'b0;
    bus.req_op = 3'($urandom_range(0, 7)); bus.req_dst = 1'b0;
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      n_checks++;
      if (rdy !== (cyc % 3 == 0)) $display("FAIL b2b_ready cyc%0d: got %b want %b", cyc, rdy, (cyc % 3 == 0));
      else n_pass++;
      n_checks++;
      if (bus.done === 1'b1 && prev_done) $display("FAIL b2b_done_consecutive cyc%0d: got 1 want 0", cyc);
      else n_pass++;
      if (bus.done === 1'b1) dones++;
      prev_done = bus.done;
      @(posedge clk);
      if (rdy && bus.req_valid) acc++;
      #1;
      if (acc == 4) bus.req_valid = 1'b0;
      else if (rdy) bus.req_op = 3'($urandom_range(0, 7));
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (acc !== 4) $display("FAIL b2b_accepts: got %0d want 4", acc);
    else n_pass++;
    n_checks++;
    if (dones !== 4) $display("FAIL b2b_dones: got %0d want 4", dones);
    else n_pass++;
    set_flags(4'b0000);
  endtask

  task automatic test_reset_mid_exec();
    set_flags(4'b1010);
    a_in = 8'h50; b_in = 8'h50; bus.d_flag = 1'b1;
    bus.req_op = 3'd0; bus.req_dst = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({strobes(), bus.alu_cin, bus.alu_decen, bus.alu_adloa, bus.alu_sboa, bus.done, bus.req_ready} !== 13'h0)
      $display("FAIL rst_exec_outputs: got %b want 0", {strobes(), bus.alu_cin, bus.alu_decen,
               bus.alu_adloa, bus.alu_sboa, bus.done, bus.req_ready});
    else n_pass++;
    n_checks++;
    if (bus.alu_reset !== 1'b1) $display("FAIL rst_exec_alu_reset: got %b want 1", bus.alu_reset);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.d_flag = 1'b0;
    m_flags = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== S_IDLE) $display("FAIL rst_exec_state: got %0d want %0d", dbg_state, S_IDLE);
    else n_pass++;
    n_checks++;
    if (flags() !== 4'b0000) $display("FAIL rst_exec_flags: got %b want 0000", flags());
    else n_pass++;
    n_checks++;
    if ({strobes(), bus.alu_adloa, bus.alu_sboa, bus.done, bus.req_ready} !== 11'b0000000_0_0_0_1)
      $display("FAIL rst_exec_after: got %b want 00000000001", {strobes(), bus.alu_adloa, bus.alu_sboa, bus.done, bus.req_ready});
    else n_pass++;
    @(posedge clk); #1;
    set_flags(4'b0001);
    n_checks++;
    if (bus.p_c !== 1'b1) $display("FAIL rst_exec_ld_c: got %b want 1", bus.p_c);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_dst = 1'b0;
    bus.d_flag = 1'b0; bus.flag_ld = 1'b0; bus.flag_ld_val = 4'h0;
    a_in = 8'h00; b_in = 8'h00; m_flags = 4'b0000;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_decimal_and_merge();
    test_random();
    test_back_to_back();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
